// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Sits behind the EX/MEM register: formats stores, runs a request/ready
// handshake to the data cache, extends load data and stalls the front of
// the pipeline while an access is outstanding.
//
// Cache handshake: dc_req is registered and held high, with dc_we/dc_addr/
// dc_wdata/dc_be stable, from the cycle after an aligned access arrives
// until the cache answers with dc_ready=1 (sampled only in WAIT) or the
// timeout expires; dc_rdata is consumed in the same cycle as dc_ready.
// TIMEOUT must be at least 1 and 2**CNT_W must exceed TIMEOUT.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_MemRd,
  input  logic        mem_MemWr,
  input  logic [2:0]  mem_Load_sel,
  input  logic [1:0]  mem_Store_sel,
  input  logic [31:0] mem_ALU_result,
  input  logic [31:0] mem_readdata2,
  input  logic [31:0] mem_readdata2_fp,
  input  logic        mem_data_sel,
  output logic        dc_req,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [3:0]  dc_be,
  input  logic        dc_ready,
  input  logic [31:0] dc_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dc_req;
  logic              r_dc_we;
  logic [31:0]       r_dc_addr;
  logic [31:0]       r_dc_wdata;
  logic [3:0]        r_dc_be;
  logic [31:0]       r_load_data;
  logic              r_bus_err;
  logic [1:0]        r_lo;
  logic [2:0]        r_ld_sel;

  logic              w_access;
  logic              w_is_store;
  logic [1:0]        w_a;
  logic              w_st_half;
  logic              w_st_word;
  logic              w_ld_half;
  logic              w_ld_word;
  logic              w_mis_cond;
  logic              w_idle;
  logic              w_wait;
  logic              w_issue;
  logic              w_timeout;
  logic [31:0]       w_sdata;
  logic [31:0]       w_st_wdata;
  logic [3:0]        w_st_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_ext;

  // A request with both MemRd and MemWr set is handled as a store.
  assign w_access   = mem_MemRd | mem_MemWr;
  assign w_is_store = mem_MemWr;
  assign w_a        = mem_ALU_result[1:0];
  assign w_idle     = (r_state == IDLE);
  assign w_wait     = (r_state == WAIT);

  // Access size decode; reserved load codes and store code 11 act as words.
  assign w_st_half = (mem_Store_sel == 2'b01);
  assign w_st_word = mem_Store_sel[1];
  assign w_ld_half = (mem_Load_sel == 3'b001) | (mem_Load_sel == 3'b101);
  assign w_ld_word = ~w_ld_half & (mem_Load_sel != 3'b000) & (mem_Load_sel != 3'b100);

  assign w_mis_cond = w_is_store ?
                      ((w_st_half & w_a[0]) | (w_st_word & (w_a != 2'b00))) :
                      ((w_ld_half & w_a[0]) | (w_ld_word & (w_a != 2'b00)));

  // Misaligned accesses never leave IDLE, so they neither stall nor request.
  assign misalign  = w_idle & w_access & w_mis_cond;
  assign w_issue   = w_idle & w_access & ~w_mis_cond;
  assign stall     = w_issue | w_wait;
  assign w_timeout = w_wait & ~dc_ready & (r_cnt == TO_LAST);

  // Store lane steering: replicate the datum across the word, enable its lanes.
  always_comb begin
    w_sdata    = mem_data_sel ? mem_readdata2_fp : mem_readdata2;
    w_st_wdata = w_sdata;
    w_st_be    = 4'b1111;
    case (mem_Store_sel)
      2'b00: begin
        w_st_wdata = {4{w_sdata[7:0]}};
        w_st_be    = 4'b0001 << w_a;
      end
      2'b01: begin
        w_st_wdata = {2{w_sdata[15:0]}};
        w_st_be    = 4'b0011 << {w_a[1], 1'b0};
      end
      default: begin
        w_st_wdata = w_sdata;
        w_st_be    = 4'b1111;
      end
    endcase
  end

  // Load extraction and extension, using the offset/size latched at issue.
  always_comb begin
    w_byte = dc_rdata[7:0];
    case (r_lo)
      2'd0:    w_byte = dc_rdata[7:0];
      2'd1:    w_byte = dc_rdata[15:8];
      2'd2:    w_byte = dc_rdata[23:16];
      default: w_byte = dc_rdata[31:24];
    endcase
    w_half   = r_lo[1] ? dc_rdata[31:16] : dc_rdata[15:0];
    w_ld_ext = dc_rdata;
    case (r_ld_sel)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_ext = {24'd0, w_byte};
      3'b101:  w_ld_ext = {16'd0, w_half};
      default: w_ld_ext = dc_rdata;
    endcase
  end

  // Next-state logic: IDLE -> WAIT on an aligned access, WAIT -> DONE on
  // ready or timeout, DONE always returns to IDLE without re-issuing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next = WAIT;
      WAIT:    if (dc_ready || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request fields, timeout counter, load result and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dc_req    <= 1'b0;
      r_dc_we     <= 1'b0;
      r_dc_addr   <= 32'd0;
      r_dc_wdata  <= 32'd0;
      r_dc_be     <= 4'd0;
      r_load_data <= 32'd0;
      r_bus_err   <= 1'b0;
      r_cnt       <= '0;
      r_lo        <= 2'd0;
      r_ld_sel    <= 3'd0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_dc_req   <= 1'b1;
            r_dc_we    <= w_is_store;
            r_dc_addr  <= {mem_ALU_result[31:2], 2'b00};
            r_dc_wdata <= w_is_store ? w_st_wdata : 32'd0;
            r_dc_be    <= w_is_store ? w_st_be : 4'b1111;
            r_cnt      <= '0;
            r_lo       <= w_a;
            r_ld_sel   <= mem_Load_sel;
          end
        end
        WAIT: begin
          if (dc_ready) begin
            r_dc_req <= 1'b0;
            if (!r_dc_we) r_load_data <= w_ld_ext;
          end else if (w_timeout) begin
            r_dc_req  <= 1'b0;
            r_bus_err <= 1'b1;
            if (!r_dc_we) r_load_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dc_req    = r_dc_req;
  assign dc_we     = r_dc_we;
  assign dc_addr   = r_dc_addr;
  assign dc_wdata  = r_dc_wdata;
  assign dc_be     = r_dc_be;
  assign load_data = r_load_data;
  assign bus_err   = r_bus_err;
  assign dbg_state = r_state;

endmodule
